// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin or fixed-priority arbitration
// and a registered output stage tagged with the source channel.
module stream_mux_rr #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned W    = 4,
    localparam int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch
);

    logic [SEL_W-1:0] last_q;
    logic [SEL_W-1:0] winner;
    logic [W-1:0]     win_data;
    logic             found;
    logic             any_valid;
    logic             load_en;
    int unsigned      rr_idx;

    assign any_valid = |in_valid;
    assign load_en   = !out_valid || out_ready;

    // Round-robin search runs last+1 .. last+N_CH modulo N_CH, so last itself is tried last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        rr_idx = 0;
        if (mode) begin
            for (int i = int'(N_CH) - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    winner = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= N_CH; k++) begin
                rr_idx = (int'(last_q) + k) % N_CH;
                if (!found && in_valid[rr_idx]) begin
                    winner = SEL_W'(rr_idx);
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        in_ready = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (winner == SEL_W'(i)) begin
                win_data    = in_data[i*W +: W];
                in_ready[i] = load_en && any_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last_q    <= SEL_W'(N_CH - 1);
        end else if (load_en) begin
            if (any_valid) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_ch    <= winner;
                last_q    <= winner;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
